// File: rtl/regfile_write_arbiter.sv
// Shares the single RegisterFile write port between an ALU (req0) and a load unit (req1) requester.
// Optional macro REGFILE_ARB_ZERO_FILTER_EN: handshake register-0 writes but never pulse write_enable for them.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 5,
  parameter int PRIORITY_MODE = 0,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ADDR_WIDTH-1:0] req0_register,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ADDR_WIDTH-1:0] req1_register,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  write_enable,
  output logic [ADDR_WIDTH-1:0] write_register,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  last_grant
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic                  grant0_s;
  logic                  grant1_s;
  logic                  we_q;
  logic                  we_d;
  logic [ADDR_WIDTH-1:0] wreg_q;
  logic [ADDR_WIDTH-1:0] wreg_d;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic                  last_grant_q;
  logic                  last_grant_d;
  logic [3:0]            starve_q;
  logic [3:0]            starve_d;

  // Combinational grant: round-robin against last_grant, or fixed priority with a starvation override.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (!reset_n) begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end else if (req0_valid && req1_valid) begin
      if (PRIORITY_MODE == 0) begin
        if (last_grant_q) begin
          grant0_s = 1'b1;
        end else begin
          grant1_s = 1'b1;
        end
      end else begin
        if (starve_q == STARVE_MAX) begin
          grant1_s = 1'b1;
        end else begin
          grant0_s = 1'b1;
        end
      end
    end else if (req0_valid) begin
      grant0_s = 1'b1;
    end else if (req1_valid) begin
      grant1_s = 1'b1;
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Next-state for the write stage, grant history and req1 starvation counter.
  always_comb begin
    we_d         = 1'b0;
    wreg_d       = wreg_q;
    wdata_d      = wdata_q;
    last_grant_d = last_grant_q;
    starve_d     = starve_q;
    if (grant0_s) begin
      wreg_d       = req0_register;
      wdata_d      = req0_data;
      last_grant_d = 1'b0;
`ifdef REGFILE_ARB_ZERO_FILTER_EN
      we_d         = (req0_register != {ADDR_WIDTH{1'b0}});
`else
      we_d         = 1'b1;
`endif
    end else if (grant1_s) begin
      wreg_d       = req1_register;
      wdata_d      = req1_data;
      last_grant_d = 1'b1;
`ifdef REGFILE_ARB_ZERO_FILTER_EN
      we_d         = (req1_register != {ADDR_WIDTH{1'b0}});
`else
      we_d         = 1'b1;
`endif
    end else begin
      we_d = 1'b0;
    end

    // req1 losing while valid counts toward a forced grant; anything else clears the streak
    if ((PRIORITY_MODE != 0) && req1_valid && grant0_s) begin
      if (starve_q >= STARVE_MAX) begin
        starve_d = STARVE_MAX;
      end else begin
        starve_d = starve_q + 4'd1;
      end
    end else begin
      starve_d = 4'd0;
    end
  end

  // State registers; async reset drops any pending write pulse immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q         <= 1'b0;
      wreg_q       <= {ADDR_WIDTH{1'b0}};
      wdata_q      <= {DATA_WIDTH{1'b0}};
      last_grant_q <= 1'b1;
      starve_q     <= 4'd0;
    end else begin
      we_q         <= we_d;
      wreg_q       <= wreg_d;
      wdata_q      <= wdata_d;
      last_grant_q <= last_grant_d;
      starve_q     <= starve_d;
    end
  end

  assign req0_ready     = grant0_s;
  assign req1_ready     = grant1_s;
  assign write_enable   = we_q;
  assign write_register = wreg_q;
  assign write_data     = wdata_q;
  assign last_grant     = last_grant_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench: a round-robin instance fed from requester queues and a fixed-priority
// instance with hold-until-accepted requesters, both compared against a queue/array reference model.
module tb_regfile_write_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int LIMIT = 4;
`ifdef REGFILE_ARB_ZERO_FILTER_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  typedef struct packed {
    logic [AW-1:0] r;
    logic [DW-1:0] d;
  } item_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [AW-1:0] req0_register, req1_register, write_register;
  logic [DW-1:0] req0_data, req1_data, write_data;
  logic          write_enable, last_grant;
  logic          f0_valid, f1_valid, f0_ready, f1_ready, f_we, f_lg;
  logic [AW-1:0] f_wreg;
  logic [DW-1:0] f_wdata;
  logic          rf_clr;
  logic [DW-1:0] rf [32];

  always #5 clk = ~clk;

  regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PRIORITY_MODE(0), .STARVE_LIMIT(LIMIT)) u_rr (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_register(req0_register), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_register(req1_register), .req1_data(req1_data),
    .write_enable(write_enable), .write_register(write_register), .write_data(write_data),
    .last_grant(last_grant));

  regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PRIORITY_MODE(1), .STARVE_LIMIT(LIMIT)) u_fix (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(f0_valid), .req0_ready(f0_ready), .req0_register(req0_register), .req0_data(req0_data),
    .req1_valid(f1_valid), .req1_ready(f1_ready), .req1_register(req1_register), .req1_data(req1_data),
    .write_enable(f_we), .write_register(f_wreg), .write_data(f_wdata),
    .last_grant(f_lg));

  // RegisterFile stand-in fed by the round-robin instance
  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (write_enable) begin
      rf[write_register] <= write_data;
    end
  end

  int            errors = 0;
  int            checks = 0;
  item_t         q0[$];
  item_t         q1[$];
  logic [DW-1:0] mrf [32];
  int            m_last = 1;
  logic          exp_we = 1'b0;
  logic [AW-1:0] exp_reg = '0;
  logic [DW-1:0] exp_data = '0;
  int            f_last = 1;
  int            m_lose = 0;
  logic          f_exp_we = 1'b0;
  int            f_prob = 0;
  logic          obs_f1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic fwd(input logic [AW-1:0] r);
    return !(ZF && (r == 5'd0));
  endfunction

  // One clock cycle: drive at posedge+1, check at negedge, advance the model after the next posedge.
  task automatic cycle();
    int g;
    int fg;
    req0_valid = (q0.size() != 0);
    req1_valid = (q1.size() != 0);
    if (q0.size() != 0) begin req0_register = q0[0].r; req0_data = q0[0].d; end
    if (q1.size() != 0) begin req1_register = q1[0].r; req1_data = q1[0].d; end
    if (req0_valid && req1_valid) g = (m_last == 1) ? 0 : 1;
    else if (req0_valid)          g = 0;
    else if (req1_valid)          g = 1;
    else                          g = -1;
    if (f0_valid && f1_valid) fg = (m_lose == LIMIT) ? 1 : 0;
    else if (f0_valid)        fg = 0;
    else if (f1_valid)        fg = 1;
    else                      fg = -1;
    @(negedge clk);
    chk("rr_ready0", req0_ready, g == 0);
    chk("rr_ready1", req1_ready, g == 1);
    chk("rr_we", write_enable, exp_we);
    if (!ZF || exp_we) begin
      chk("rr_wreg", write_register, exp_reg);
      chk("rr_wdata", write_data, exp_data);
    end
    chk("rr_last_grant", last_grant, m_last);
    chk("fix_ready0", f0_ready, fg == 0);
    chk("fix_ready1", f1_ready, fg == 1);
    chk("fix_we", f_we, f_exp_we);
    chk("fix_last_grant", f_lg, f_last);
    obs_f1 = f1_ready;
    @(posedge clk);
    #1;
    if (exp_we) mrf[exp_reg] = exp_data;
    exp_we = 1'b0;
    if (g == 0) begin
      exp_we = fwd(q0[0].r); exp_reg = q0[0].r; exp_data = q0[0].d; m_last = 0;
      void'(q0.pop_front());
    end else if (g == 1) begin
      exp_we = fwd(q1[0].r); exp_reg = q1[0].r; exp_data = q1[0].d; m_last = 1;
      void'(q1.pop_front());
    end
    f_exp_we = 1'b0;
    if (fg == 0) begin f_exp_we = fwd(req0_register); f_last = 0; end
    else if (fg == 1) begin f_exp_we = fwd(req1_register); f_last = 1; end
    if (f1_valid && fg == 0) m_lose = (m_lose < LIMIT) ? m_lose + 1 : LIMIT;
    else                     m_lose = 0;
    if (fg == 0) f0_valid = 1'b0;
    if (fg == 1) f1_valid = 1'b0;
    if (!f0_valid) f0_valid = ($urandom_range(0, 99) < f_prob);
    if (!f1_valid) f1_valid = ($urandom_range(0, 99) < f_prob);
  endtask

  // Asynchronous reset at a random point inside a cycle where a write pulse is live.
  task automatic mid_reset();
    #($urandom_range(1, 3));
    chk("pre_reset_we", write_enable, exp_we);
    reset_n = 1'b0;
    #1;
    chk("rst_we", write_enable, 1'b0);
    chk("rst_wreg", write_register, 5'd0);
    chk("rst_wdata", write_data, 32'd0);
    chk("rst_last_grant", last_grant, 1'b1);
    chk("rst_ready0", req0_ready, 1'b0);
    chk("rst_ready1", req1_ready, 1'b0);
    chk("rst_fix_we", f_we, 1'b0);
    chk("rst_fix_last_grant", f_lg, 1'b1);
    exp_we = 1'b0; exp_reg = '0; exp_data = '0; m_last = 1;
    f_exp_we = 1'b0; f_last = 1; m_lose = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic push(input int which, input logic [AW-1:0] r, input logic [DW-1:0] d);
    item_t it;
    it.r = r;
    it.d = d;
    if (which == 0) q0.push_back(it);
    else            q1.push_back(it);
  endtask

  initial begin
    logic [9:0]    seq;
    logic [DW-1:0] zero_exp;
    bit            did_reset;
    for (int i = 0; i < 32; i++) mrf[i] = '0;
    reset_n = 1'b0; rf_clr = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1; f0_valid = 1'b1; f1_valid = 1'b1;
    req0_register = 5'd3; req1_register = 5'd4; req0_data = 32'h1; req1_data = 32'h2;
    repeat (2) @(posedge clk);
    #1;
    chk("init_we", write_enable, 1'b0);
    chk("init_wreg", write_register, 5'd0);
    chk("init_wdata", write_data, 32'd0);
    chk("init_last_grant", last_grant, 1'b1);
    chk("init_ready0", req0_ready, 1'b0);
    chk("init_ready1", req1_ready, 1'b0);
    chk("init_fix_ready0", f0_ready, 1'b0);
    chk("init_fix_last_grant", f_lg, 1'b1);
    reset_n = 1'b1; rf_clr = 1'b0; f0_valid = 1'b0; f1_valid = 1'b0;

    // single req0 write, latency 1
    push(0, 5'd5, 32'h12345678);
    repeat (3) cycle();
    chk("rf_reg5", rf[5], 32'h12345678);

    // make last_grant=1, then both valid: grants 0,1,0,1
    push(1, 5'd9, 32'h55);
    cycle();
    push(0, 5'd2, 32'hA); push(1, 5'd3, 32'hB);
    push(0, 5'd2, 32'hA); push(1, 5'd3, 32'hB);
    repeat (6) cycle();
    chk("rf_reg2", rf[2], 32'hA);
    chk("rf_reg3", rf[3], 32'hB);

    // same destination: req0 first, req1 last so it wins
    push(0, 5'd7, 32'h1); push(1, 5'd7, 32'h2);
    repeat (4) cycle();
    chk("rf_reg7", rf[7], 32'h2);

    // register-0 write
    push(1, 5'd0, 32'hFFFF_FFFF);
    repeat (3) cycle();
    zero_exp = ZF ? 32'h0 : 32'hFFFF_FFFF;
    chk("rf_reg0", rf[0], zero_exp);

    // fixed priority starvation guard under continuous contention
    seq = 10'b1000010000;
    f0_valid = 1'b1; f1_valid = 1'b1; f_prob = 100;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("fix_seq", obs_f1, seq[i]);
    end

    // randomized traffic with one asynchronous reset mid-stream
    f_prob = 50;
    did_reset = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (q0.size() < 2 && $urandom_range(0, 99) < 60) push(0, 5'($urandom_range(0, 7)), $urandom);
      if (q1.size() < 2 && $urandom_range(0, 99) < 60) push(1, 5'($urandom_range(0, 7)), $urandom);
      cycle();
      if (!did_reset && i >= 150 && exp_we) begin
        mid_reset();
        did_reset = 1'b1;
      end
    end
    chk("reset_exercised", did_reset, 1'b1);
    f_prob = 0;
    for (int i = 0; i < 12; i++) cycle();
    for (int i = 0; i < 32; i++) chk($sformatf("rf_final_%0d", i), rf[i], mrf[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
